// File: rtl/ars_word_reader.sv
// Word-serial reader for a GF(2^233) element: snapshots a full element on LOAD
// and streams it LSW first as 32-bit words over a valid/ready handshake.
module ars_word_reader #(
  parameter int WIDTH = 233,
  parameter int WORD  = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] IN,
  output logic             BUSY,
  output logic [WORD-1:0]  DOUT,
  output logic             DOUT_VALID,
  input  logic             DOUT_READY,
  output logic             DOUT_LAST,
  output logic [2:0]       WORD_IDX,
  output logic             DONE,
  output logic             OVERRUN
);

  localparam int NWORDS = (WIDTH + WORD - 1) / WORD;
  localparam int PADW   = NWORDS * WORD;
  localparam logic [2:0] LAST_IDX = 3'(NWORDS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shadow, shadow_n;
  logic [PADW-1:0]  pad;
  logic [2:0]       idx_nx;
  logic [2:0]       idx_n;
  logic [WORD-1:0]  dout_n;
  logic             valid_n, last_n, busy_n, done_n, overrun_n;

  // Zero-extend so the top word carries zeros above WIDTH.
  assign pad    = PADW'(shadow);
  assign idx_nx = WORD_IDX + 3'd1;

  always_comb begin
    state_n   = state;
    shadow_n  = shadow;
    idx_n     = WORD_IDX;
    dout_n    = DOUT;
    valid_n   = DOUT_VALID;
    last_n    = DOUT_LAST;
    busy_n    = BUSY;
    done_n    = 1'b0;
    overrun_n = OVERRUN;
    unique case (state)
      IDLE: begin
        if (LOAD) begin
          state_n   = SEND;
          shadow_n  = IN;
          idx_n     = '0;
          dout_n    = IN[WORD-1:0];
          valid_n   = 1'b1;
          last_n    = (LAST_IDX == 3'd0);
          busy_n    = 1'b1;
          overrun_n = 1'b0;
        end
      end
      SEND: begin
        if (LOAD) overrun_n = 1'b1;
        if (DOUT_VALID && DOUT_READY) begin
          if (WORD_IDX == LAST_IDX) begin
            state_n = IDLE;
            valid_n = 1'b0;
            last_n  = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            idx_n  = idx_nx;
            dout_n = pad[WORD*int'(idx_nx) +: WORD];
            last_n = (idx_nx == LAST_IDX);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      shadow     <= '0;
      WORD_IDX   <= '0;
      DOUT       <= '0;
      DOUT_VALID <= 1'b0;
      DOUT_LAST  <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      state      <= state_n;
      shadow     <= shadow_n;
      WORD_IDX   <= idx_n;
      DOUT       <= dout_n;
      DOUT_VALID <= valid_n;
      DOUT_LAST  <= last_n;
      BUSY       <= busy_n;
      DONE       <= done_n;
      OVERRUN    <= overrun_n;
    end
  end

endmodule

// File: tb/tb_ars_word_reader.sv
// Scoreboard bench for ars_word_reader: expected words queued at LOAD,
// popped and compared as the DUT transfers them.
module tb_ars_word_reader;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         LOAD = 1'b0;
  logic [232:0] IN = '0;
  logic         BUSY;
  logic [31:0]  DOUT;
  logic         DOUT_VALID;
  logic         DOUT_READY = 1'b0;
  logic         DOUT_LAST;
  logic [2:0]   WORD_IDX;
  logic         DONE;
  logic         OVERRUN;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  ars_word_reader #(.WIDTH(233), .WORD(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .LOAD(LOAD), .IN(IN), .BUSY(BUSY),
    .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY),
    .DOUT_LAST(DOUT_LAST), .WORD_IDX(WORD_IDX), .DONE(DONE), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_elem(input logic [232:0] v);
    for (int n = 0; n < 7; n++) exp_q.push_back(v[n*32 +: 32]);
    exp_q.push_back({23'b0, v[232:224]});
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the capture edge.
  task automatic do_load(input logic [232:0] v);
    LOAD = 1'b1;
    IN   = v;
    push_elem(v);
    @(negedge CLK);
    LOAD = 1'b0;
  endtask

  task automatic drain(input bit random_rdy, input bit inject, output int dones);
    int got = 0;
    int cyc = 0;
    bit stalled = 0;
    bit rdy;
    logic [31:0] pd, e;
    logic [2:0]  pi;
    logic        pl;
    while (got < 8 && cyc < 200) begin
      if (stalled) begin
        n_tests++;
        if (DOUT !== pd || WORD_IDX !== pi || DOUT_LAST !== pl) begin
          n_fail++;
          $display("FAIL stall_hold: dout=%h idx=%0d last=%b, required dout=%h idx=%0d last=%b",
                   DOUT, WORD_IDX, DOUT_LAST, pd, pi, pl);
        end
      end
      n_tests++;
      if (DOUT_VALID !== 1'b1 || BUSY !== 1'b1 || DONE !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_flags: valid=%b busy=%b done=%b, required 1 1 0", DOUT_VALID, BUSY, DONE);
      end
      if (inject && got > 3) begin
        n_tests++;
        if (OVERRUN !== 1'b1) begin
          n_fail++;
          $display("FAIL overrun_set: overrun=%b, required 1", OVERRUN);
        end
      end
      rdy = random_rdy ? bit'($urandom_range(0, 1)) : 1'b1;
      DOUT_READY = rdy;
      LOAD = inject && rdy && (got == 3 || got == 7);
      if (inject) IN = {1'b1, {29{8'hA5}}, 4'h3};
      if (rdy) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        n_tests++;
        if (DOUT !== e || WORD_IDX !== 3'(got) || DOUT_LAST !== (got == 7)) begin
          n_fail++;
          $display("FAIL word%0d: dout=%h idx=%0d last=%b, required dout=%h idx=%0d last=%b",
                   got, DOUT, WORD_IDX, DOUT_LAST, e, got, (got == 7));
        end
        got++;
        stalled = 0;
      end else begin
        stalled = 1;
        pd = DOUT;
        pi = WORD_IDX;
        pl = DOUT_LAST;
      end
      @(negedge CLK);
      cyc++;
    end
    LOAD = 1'b0;
    n_tests++;
    if (got != 8) begin
      n_fail++;
      $display("FAIL stream_timeout: got %0d words, required 8", got);
    end
    n_tests++;
    if (DONE !== 1'b1 || BUSY !== 1'b0 || DOUT_VALID !== 1'b0 || DOUT_LAST !== 1'b0) begin
      n_fail++;
      $display("FAIL end_flags: done=%b busy=%b valid=%b last=%b, required 1 0 0 0",
               DONE, BUSY, DOUT_VALID, DOUT_LAST);
    end
    dones = (DONE === 1'b1) ? 1 : 0;
  endtask

  task automatic check_reset_vals(input string tag);
    n_tests++;
    if (DOUT !== '0 || DOUT_VALID !== 1'b0 || DOUT_LAST !== 1'b0 || WORD_IDX !== '0 ||
        BUSY !== 1'b0 || DONE !== 1'b0 || OVERRUN !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: dout=%h valid=%b last=%b idx=%0d busy=%b done=%b ovr=%b, required all zero",
               tag, DOUT, DOUT_VALID, DOUT_LAST, WORD_IDX, BUSY, DONE, OVERRUN);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    #12;
    check_reset_vals("reset_state");
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_basic();
    int d;
    do_load(233'h1_23456789_ABCDEF01_13579BDF_2468ACE0_DEADBEEF_CAFEF00D_0BADC0DE);
    drain(0, 0, d);
    @(negedge CLK);
    n_tests++;
    if (DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL done_single_pulse: done=%b, required 0", DONE);
    end
  endtask

  task automatic test_mask();
    int d;
    do_load('1);
    n_tests++;
    if (exp_q[7] !== 32'h0000_01FF) begin
      n_fail++;
      $display("FAIL mask_model: word7=%h, required 000001ff", exp_q[7]);
    end
    drain(0, 0, d);
    @(negedge CLK);
  endtask

  task automatic test_backpressure();
    logic [255:0] t;
    int d;
    for (int n = 0; n < 8; n++) t[n*32 +: 32] = 32'h0000_0100 * n;
    do_load(t[232:0]);
    drain(1, 0, d);
    @(negedge CLK);
  endtask

  task automatic test_overrun();
    int d;
    do_load({1'b0, {7{32'h1111_2222}}});
    drain(0, 1, d);
    n_tests++;
    if (OVERRUN !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_sticky: overrun=%b, required 1", OVERRUN);
    end
    @(negedge CLK);
    do_load({1'b1, {7{32'h3333_4444}}});
    n_tests++;
    if (OVERRUN !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear: overrun=%b, required 0", OVERRUN);
    end
    drain(0, 0, d);
    @(negedge CLK);
  endtask

  task automatic test_reset_midstream();
    do_load({1'b1, {7{32'h5555_6666}}});
    DOUT_READY = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge CLK);
    n_tests++;
    if (WORD_IDX !== 3'd5) begin
      n_fail++;
      $display("FAIL pre_reset_idx: idx=%0d, required 5", WORD_IDX);
    end
    #1 RST_N = 1'b0;
    #1 check_reset_vals("async_reset");
    exp_q.delete();
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_tests++;
      if (DOUT_VALID !== 1'b0 || BUSY !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_idle: valid=%b busy=%b, required 0 0", DOUT_VALID, BUSY);
      end
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    do_load({1'b0, {7{32'h7777_8888}}});
    drain(0, 0, d1);
    do_load({1'b1, {7{32'h9999_AAAA}}});
    drain(0, 0, d2);
    n_tests++;
    if (d1 + d2 != 2 || OVERRUN !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back: done_pulses=%0d overrun=%b, required 2 and 0", d1 + d2, OVERRUN);
    end
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mask();
    test_backpressure();
    test_overrun();
    test_reset_midstream();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
